// File: rtl/tlb_xlate_arbiter.sv
// Purpose : round-robin share of the single TLB translation port between NUM_REQ requesters.
// Latency : accept at T, TRANS_RQST at T+1, RSP_VALID one cycle after the DONE_TRANS rising edge (min 2).
// Backpr. : one translation in flight; REQ_READY only in IDLE, requesters hold REQ_VALID until accepted.
//
// Ports:
//   clk, rst_n                        clock (rising edge), asynchronous active-low reset
//   REQ_VALID/REQ_SPEC/REQ_VADDR      per-requester request, spec flag, flattened vaddr (i*VA_W +: VA_W)
//   REQ_READY                         one-hot combinational accept (IDLE only)
//   RSP_VALID                         one-hot single-cycle response pulse
//   RSP_PADDR/RSP_TLB_HIT/RSP_SPEC_HIT captured TLB result, held between responses
//   RSP_ERR                           watchdog expiry flag, qualified by RSP_VALID
//   BUSY                              high whenever not IDLE
//   TRANS_RQST/SPEC_TLB_RQST/VIRT_ADDR_LOOKUP  request side of the TLB port
//   DONE_TRANS/PHY_ADDR_TRANS/TLB_HIT/SPEC_HIT completion side of the TLB port
//
// Optional feature: define TLB_ARB_TIMEOUT_EN to enable the WAIT-state watchdog
// (TIMEOUT_CYCLES WAIT cycles without completion -> error response).

module tlb_xlate_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int VA_W           = 9,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      REQ_VALID,
    input  logic [NUM_REQ-1:0]      REQ_SPEC,
    input  logic [NUM_REQ*VA_W-1:0] REQ_VADDR,
    output logic [NUM_REQ-1:0]      REQ_READY,
    output logic [NUM_REQ-1:0]      RSP_VALID,
    output logic [VA_W-1:0]         RSP_PADDR,
    output logic                    RSP_TLB_HIT,
    output logic                    RSP_SPEC_HIT,
    output logic                    RSP_ERR,
    output logic                    BUSY,
    output logic                    TRANS_RQST,
    output logic                    SPEC_TLB_RQST,
    output logic [VA_W-1:0]         VIRT_ADDR_LOOKUP,
    input  logic                    DONE_TRANS,
    input  logic [VA_W-1:0]         PHY_ADDR_TRANS,
    input  logic                    TLB_HIT,
    input  logic                    SPEC_HIT
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Elaboration-time sanity check of the configuration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("tlb_xlate_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     id_q, id_d;
    logic [VA_W-1:0]   vaddr_q, vaddr_d;
    logic              spec_q, spec_d;
    logic              done_q;
    logic [VA_W-1:0]   paddr_q, paddr_d;
    logic              tlb_hit_q, tlb_hit_d;
    logic              spec_hit_q, spec_hit_d;

    // Only a fresh rising edge completes a transaction; a level left over
    // from the previous translation must not retire the next one.
    logic done_rise;
    assign done_rise = DONE_TRANS & ~done_q;

    // Round-robin winner: first valid requester after the pointer, wrapping.
    logic          win_vld;
    logic [IW-1:0] win_id;
    logic [IW:0]   cand;

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!win_vld && REQ_VALID[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_id  = cand[IW-1:0];
            end
        end
    end

`ifdef TLB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // Next-state and result capture.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        vaddr_d    = vaddr_q;
        spec_d     = spec_q;
        paddr_d    = paddr_q;
        tlb_hit_d  = tlb_hit_q;
        spec_hit_d = spec_hit_q;
`ifdef TLB_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    id_d    = win_id;
                    vaddr_d = REQ_VADDR[int'(win_id)*VA_W +: VA_W];
                    spec_d  = REQ_SPEC[win_id];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef TLB_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                // A TLB that answers in the issue cycle skips WAIT entirely.
                if (done_rise) begin
                    paddr_d    = PHY_ADDR_TRANS;
                    tlb_hit_d  = TLB_HIT;
                    spec_hit_d = SPEC_HIT;
`ifdef TLB_ARB_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                    state_d    = S_RESP;
                end else begin
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // done_rise takes priority over a watchdog expiry in the same cycle.
                if (done_rise) begin
                    paddr_d    = PHY_ADDR_TRANS;
                    tlb_hit_d  = TLB_HIT;
                    spec_hit_d = SPEC_HIT;
`ifdef TLB_ARB_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                    state_d    = S_RESP;
                end
`ifdef TLB_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    paddr_d    = '0;
                    tlb_hit_d  = 1'b0;
                    spec_hit_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                ptr_d   = id_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= IW'(NUM_REQ - 1);
            id_q       <= '0;
            vaddr_q    <= '0;
            spec_q     <= 1'b0;
            done_q     <= 1'b0;
            paddr_q    <= '0;
            tlb_hit_q  <= 1'b0;
            spec_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            vaddr_q    <= vaddr_d;
            spec_q     <= spec_d;
            done_q     <= DONE_TRANS;
            paddr_q    <= paddr_d;
            tlb_hit_q  <= tlb_hit_d;
            spec_hit_q <= spec_hit_d;
        end
    end

`ifdef TLB_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign RSP_ERR = err_q;
`else
    assign RSP_ERR = 1'b0;
`endif

    // Outputs decoded from state; all of them fall to zero as soon as reset asserts.
    always_comb begin
        REQ_READY = '0;
        RSP_VALID = '0;
        if (rst_n && state_q == S_IDLE && win_vld) begin
            REQ_READY[win_id] = 1'b1;
        end
        if (state_q == S_RESP) begin
            RSP_VALID[id_q] = 1'b1;
        end
    end

    assign BUSY             = (state_q != S_IDLE);
    assign TRANS_RQST       = (state_q == S_ISSUE);
    assign SPEC_TLB_RQST    = (state_q == S_ISSUE) & spec_q;
    assign VIRT_ADDR_LOOKUP = (state_q == S_ISSUE || state_q == S_WAIT) ? vaddr_q : '0;
    assign RSP_PADDR        = paddr_q;
    assign RSP_TLB_HIT      = tlb_hit_q;
    assign RSP_SPEC_HIT     = spec_hit_q;

endmodule
